seq_shift_unit: RTL and testbench

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/seq_shift_unit.sv | 144 ++++++++++++++
 tb/tb_seq_shift_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// ----------------------------------------------------------------------------
// seq_shift_unit
//
// Multi-cycle barrel-shift replacement: shifts or rotates a 32-bit operand one
// bit position per clock. Out-of-range logical/arithmetic shifts short-cut
// straight to their saturated result.
//
// Ports
//   clk       : single clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   start     : request strobe, accepted in IDLE or DONE only
//   op        : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   inp       : operand, captured when start is accepted
//   shiftamt  : full-width shift amount, captured when start is accepted
//   busy      : high while in LOAD or SHIFT
//   done      : one-cycle pulse when out holds a fresh result
//   out       : result register, held until the next result is written
// ----------------------------------------------------------------------------
module seq_shift_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] inp,
    input  logic [W-1:0] shiftamt,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t       state;
    logic [1:0]   op_q;
    logic [W-1:0] amt_q;
    logic [W-1:0] work;
    logic [5:0]   count;

    logic [5:0]   n_eff;
    logic         sat;
    logic [W-1:0] sat_value;
    logic [W-1:0] step;

    // Effective count and saturation decision, evaluated from the captured
    // operands while in LOAD. ROR wraps modulo 32 and therefore never
    // saturates; the other ops compare the whole shift amount against 31.
    always_comb begin
        sat   = 1'b0;
        n_eff = {1'b0, amt_q[4:0]};
        if (op_q != OP_ROR && amt_q > W'(31)) begin
            sat   = 1'b1;
            n_eff = '0;
        end
    end

    // Saturated result: sign fill for SRA, zero for SLL/SRL.
    always_comb begin
        sat_value = (op_q == OP_SRA) ? {W{work[W-1]}} : '0;
    end

    // One-bit step applied to the working register on every SHIFT cycle.
    always_comb begin
        case (op_q)
            OP_SLL:  step = {work[W-2:0], 1'b0};
            OP_SRL:  step = {1'b0, work[W-1:1]};
            OP_SRA:  step = {work[W-1], work[W-1:1]};
            default: step = {work[0], work[W-1:1]};
        endcase
    end

    // Main sequencer. busy and done are registered alongside the state so
    // they change on the same edge as the state they describe. out is only
    // written on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            amt_q <= '0;
            work  <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        amt_q <= shiftamt;
                        work  <= inp;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (sat) begin
                        out   <= sat_value;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (n_eff == 6'd0) begin
                        out   <= work;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= n_eff;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work  <= step;
                    count <= count - 6'd1;
                    // The last step's value goes straight into out.
                    if (count == 6'd1) begin
                        out   <= step;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// ----------------------------------------------------------------------------
// tb_seq_shift_unit
//
// Self-checking bench for seq_shift_unit. Directed cases cover the reference
// scenarios (basic shift, saturation, ROR wrap, zero count, ignored start,
// mid-operation reset, back-to-back); a randomized loop follows. Expected
// results and latencies come from an arithmetic model of the shift rules.
// ----------------------------------------------------------------------------
module tb_seq_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] inp;
    logic [31:0] shiftamt;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;
    logic [31:0] expOut;

    seq_shift_unit #(.W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .inp      (inp),
        .shiftamt (shiftamt),
        .busy     (busy),
        .done     (done),
        .out      (out)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result straight from the arithmetic meaning of each op.
    function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] amt);
        int r;
        case (o)
            2'b00: refResult = (amt > 31) ? 32'h0 : (a << amt);
            2'b01: refResult = (amt > 31) ? 32'h0 : (a >> amt);
            2'b10: refResult = (amt > 31) ? {32{a[31]}} : 32'($signed(a) >>> amt);
            default: begin
                r = int'(amt % 32);
                refResult = (r == 0) ? a : ((a >> r) | (a << (32 - r)));
            end
        endcase
    endfunction

    // Cycles from the accepting edge to the done cycle.
    function automatic int refLatency(input logic [1:0] o, input logic [31:0] amt);
        int n;
        if (o == 2'b11) n = int'(amt % 32);
        else if (amt > 31) n = 0;
        else n = int'(amt);
        refLatency = n + 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive operands with start high across one rising edge. Called #1 after
    // an edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] amt);
        op       = o;
        inp      = a;
        shiftamt = amt;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Follow an accepted operation cycle by cycle up to its done pulse.
    // Optionally fires a spurious start with junk operands while busy.
    task automatic trackOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] amt,
                           input bit poke);
        int lat;
        int pokeCyc;
        logic [31:0] res;
        lat = refLatency(o, amt);
        res = refResult(o, a, amt);
        pokeCyc = (poke && lat >= 3) ? int'($urandom_range(1, lat - 2)) : -1;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            checkOutput($sformatf("busy c%0d", c), {31'b0, busy}, {31'b0, (c < lat)});
            checkOutput($sformatf("done c%0d", c), {31'b0, done}, {31'b0, (c == lat)});
            if (c < lat) checkOutput("out held", out, expOut);
            if (c == pokeCyc) begin
                start = 1'b1;
                inp = $urandom;
                shiftamt = 32'($urandom_range(0, 40));
                op = 2'($urandom_range(0, 3));
            end
        end
        start = 1'b0;
        checkOutput($sformatf("out op%0d amt%0d", o, amt), out, res);
        expOut = res;
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] amt,
                         input bit poke);
        applyStimulus(o, a, amt);
        trackOp(o, a, amt, poke);
    endtask

    // Let the unit fall back to IDLE, bounded so a stuck design cannot hang.
    task automatic settle();
        int k;
        k = 0;
        @(posedge clk);
        #1;
        while ((busy || done) && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 80) checkOutput("settle timeout", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] ramt;
        start    = 1'b0;
        op       = 2'b00;
        inp      = 32'h0;
        shiftamt = 32'h0;
        expOut   = 32'h0;
        rst_n    = 1'b0;
        #1;
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        checkOutput("reset done", {31'b0, done}, 32'h0);
        checkOutput("reset out", out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic SLL by 4.
        runOp(2'b00, 32'h0000_0001, 32'd4, 1'b0);
        settle();
        // Saturation: SRA sign fill, SRL zero.
        runOp(2'b10, 32'h8000_0000, 32'd40, 1'b0);
        settle();
        runOp(2'b01, 32'h8000_0000, 32'd40, 1'b0);
        settle();
        // ROR wraps 36 to 4.
        runOp(2'b11, 32'h0000_00F1, 32'd36, 1'b0);
        settle();
        // ROR by 32 behaves as zero count.
        runOp(2'b11, 32'h1234_5678, 32'd32, 1'b0);
        settle();
        // Zero count SRL.
        runOp(2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0);
        settle();
        // Spurious start during a long operation is ignored.
        runOp(2'b01, 32'hF0F0_1234, 32'd12, 1'b1);
        settle();
        // Boundary amounts 31 and 32 for SLL.
        runOp(2'b00, 32'h0000_0003, 32'd31, 1'b0);
        settle();
        runOp(2'b00, 32'h0000_0003, 32'd32, 1'b0);
        settle();

        // Mid-operation reset aborts with no done pulse.
        applyStimulus(2'b00, 32'h0000_0001, 32'd20);
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", {31'b0, busy}, 32'h0);
        checkOutput("abort done", {31'b0, done}, 32'h0);
        checkOutput("abort out", out, 32'h0);
        expOut = 32'h0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("abort no done", {31'b0, done}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp(2'b10, 32'h8000_00F0, 32'd5, 1'b0);
        settle();

        // Back-to-back: second start raised during the first done cycle.
        runOp(2'b00, 32'h0000_00A5, 32'd3, 1'b0);
        runOp(2'b11, 32'hDEAD_BEEF, 32'd7, 1'b0);
        runOp(2'b10, 32'h8765_4321, 32'd33, 1'b0);
        settle();

        // Randomized operations, occasionally chained back-to-back.
        for (int t = 0; t < 40; t++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: ramt = 32'($urandom_range(0, 31));
                1: ramt = 32'($urandom_range(28, 40));
                2: ramt = $urandom;
                default: ramt = 32'($urandom_range(0, 8));
            endcase
            runOp(ro, ra, ramt, ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 2) != 0) settle();
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
